frame_serializer: RTL and testbench
===================================

# frame_serializer

Upstream feeder stage for the optional-port consumer module (port_b always present; port_a/port_c present only when the `DEFINE_A` compile define is set). Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per cycle on o_port_b. When `DEFINE_A` is defined, it also drives frame-start (o_port_a) and frame-last (o_port_c) strobes. An optional programmable idle gap separates consecutive frames.

## Interface
- WIDTH, 10, bits per frame; legal range 1..64.
- IDLE_GAP, 1, idle cycles forced between frames; legal range 0..15.
- MSB_FIRST, 0, 0 = LSB shifted first, 1 = MSB shifted first.
- One clock; reset is asynchronous and active-low. Ports: i_clk and i_rst_n.
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  WIDTH  word to serialize; sampled on accept.
- o_port_b  output  1  serial data bit.
- o_port_a  output  1  frame-start strobe; exists only when `DEFINE_A` is defined.
- o_port_c  output  1  frame-last strobe; exists only when `DEFINE_A` is defined.
- o_busy  output  1  high in SHIFT or GAP.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- Accept condition: i_valid && o_ready at a rising edge.
- IDLE:
  - o_ready = 1.
  - On accept: load the shift register with i_data, set bit counter = WIDTH-1, go to SHIFT.
- SHIFT:
  - o_port_b = the current head bit: bit 0 if MSB_FIRST=0, bit WIDTH-1 if MSB_FIRST=1.
  - Each cycle: shift by one and decrement the counter.
  - o_port_a = 1 only in the first SHIFT cycle of a frame.
  - o_port_c = 1 only in the cycle where counter == 0.
  - At counter == 0:
    - IDLE_GAP > 0: load gap counter with IDLE_GAP-1, go to GAP.
    - IDLE_GAP == 0: o_ready = 1 in this cycle. On accept, reload and stay in SHIFT (back-to-back frames). Otherwise go to IDLE.
- GAP:
  - o_port_b, o_port_a and o_port_c are 0.
  - Decrement the gap counter; at 0, go to IDLE.
- o_ready is 0 in all other SHIFT cycles and in GAP.
- i_data is ignored unless accepted. i_valid may drop without being accepted; there is no stickiness requirement upstream.
- Widths: bit counter is $clog2(WIDTH) bits (minimum 1); gap counter is 4 bits.
- WIDTH=1: a single SHIFT cycle with o_port_a and o_port_c both 1.
- Without `DEFINE_A`: the strobe logic is not generated; the data path and FSM are identical.

## Timing
- o_port_b, o_port_a, o_port_c and o_busy are registered. o_ready is combinational from state and counter only; it never depends on i_valid.
- Latency: accept at edge t puts bit 0 on o_port_b during cycle t+1. The last bit appears during cycle t+WIDTH.
- Next accept is possible:
  - at edge t+WIDTH when IDLE_GAP=0;
  - at edge t+WIDTH+IDLE_GAP+1 otherwise (one IDLE cycle after GAP).
- Throughput with IDLE_GAP=0: one word per WIDTH cycles, with no bubble.
- Reset values: state IDLE, o_ready 1, o_port_b/o_port_a/o_port_c/o_busy 0, shift register 0, counters 0.
- Reset asserted mid-frame: outputs clear immediately (asynchronous) and the partial frame is dropped. After release, the first edge can accept a new word.

## Structure
- Shared package frame_serializer_pkg holds:
  - the state enum typedef (IDLE, SHIFT, GAP);
  - the gap counter width constant (4);
  - the default WIDTH constant (10), shared with the consumer's 10-bit registers.
- One sub-module is natural: gap_down_counter. It is a 4-bit loadable down-counter with load, enable and a zero flag, and is reused by other idle-spacing stages.
- The `DEFINE_A` guard wraps both the o_port_a/o_port_c port declarations and their driver logic.

## Test plan
- Reset then single frame:
  - Stimulus: WIDTH=10, MSB_FIRST=0, IDLE_GAP=1; accept 10'h2A5 at edge t.
  - Required: o_port_b over cycles t+1..t+10 = 1,0,1,0,0,1,0,1,0,1. o_port_a high at t+1 only. o_port_c high at t+10 only. o_ready low t+1..t+11, high at t+12.
- Back-to-back:
  - Stimulus: IDLE_GAP=0; 3 words 10'h3FF, 10'h000, 10'h155 with i_valid held high.
  - Required: 30 contiguous bits with no gap; o_port_a pulses at cycles 1, 11, 21; o_port_c pulses at cycles 10, 20, 30.
- MSB_FIRST=1:
  - Stimulus: word 10'h200.
  - Required: first bit 1, then nine 0s.
- Gap spacing:
  - Stimulus: IDLE_GAP=15; i_valid held high.
  - Required: frame starts are exactly WIDTH+16 cycles apart; o_busy low for exactly one cycle between frames.
- WIDTH=1 corner:
  - Stimulus: accept 1'b1.
  - Required: a single cycle with o_port_b=1, o_port_a=1, o_port_c=1.
- Reset mid-frame:
  - Stimulus: assert i_rst_n low at bit 4 of a frame.
  - Required: all outputs 0 within the same cycle and o_ready=1. After release, a new word serializes correctly from bit 0.

Source files
------------

// File: rtl/frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_serializer_pkg
// Description : Shared types and constants for the frame serializer and its
//               idle-spacing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_serializer_pkg;

  // Serializer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Width of the inter-frame gap counter (gap of up to 15 idle cycles)
  localparam int GAP_CNT_W = 4;

  // Default frame width, matched to the downstream consumer's 10-bit registers
  localparam int DEFAULT_WIDTH = 10;

  // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gap_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : gap_down_counter
// Description : Loadable down-counter with enable and zero flag; used to time
//               idle spacing between frames. Saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gap_down_counter
  import frame_serializer_pkg::*;
#(
  parameter int CNT_W = GAP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over counting; counting stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : frame_serializer
// Description : Accepts WIDTH-bit words over valid/ready and shifts them out
//               one bit per cycle, with optional frame-start/frame-last
//               strobes and a programmable idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int IDLE_GAP  = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_port_b,
`ifdef DEFINE_A
  output logic             o_port_a,
  output logic             o_port_c,
`endif
  output logic             o_busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (IDLE_GAP > 0) ? GAP_CNT_W'(IDLE_GAP - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic             last_bit;
  logic             gap_load;
  logic             gap_en;
  logic             gap_zero;

  // Bit currently at the output end of a word
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Word with the head bit consumed
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // Ready depends only on state and counter, never on i_valid
  always_comb begin
    last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
    o_ready  = (state == ST_IDLE) || (last_bit && (IDLE_GAP == 0));
    accept   = i_valid && o_ready;
  end

  // Next-state, shift-register and counter update
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_nxt = i_data;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_nxt = shift_once(shreg);
        if (bit_cnt != '0) begin
          cnt_nxt = bit_cnt - CW'(1);
        end else if (IDLE_GAP > 0) begin
          gap_load  = 1'b1;
          state_nxt = ST_GAP;
        end else if (accept) begin
          // back-to-back frame: reload without a bubble
          shreg_nxt = i_data;
          cnt_nxt   = CW'(WIDTH - 1);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered serial outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      o_port_b <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= cnt_nxt;
      o_port_b <= (state_nxt == ST_SHIFT) ? head_bit(shreg_nxt) : 1'b0;
      o_busy   <= (state_nxt != ST_IDLE);
    end
  end

  gap_down_counter #(
    .CNT_W(GAP_CNT_W)
  ) u_gap_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (gap_load),
    .load_val(GAP_LOAD),
    .en      (gap_en),
    .zero    (gap_zero)
  );

`ifdef DEFINE_A
  // Frame-start marks the first bit after an accept; frame-last marks count 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_port_a <= 1'b0;
      o_port_c <= 1'b0;
    end else begin
      o_port_a <= (state_nxt == ST_SHIFT) && accept;
      o_port_c <= (state_nxt == ST_SHIFT) && (cnt_nxt == '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_serializer
// Description : Scoreboard bench for frame_serializer over four parameter
//               sets (gap 1, gap 0, gap 15 MSB-first, width 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_serializer;

  typedef struct {
    logic busy;
    logic b;
    logic a;
    logic c;
    logic ready;
    int   idx;
  } exp_t;

  typedef struct {
    logic        v;
    logic [63:0] d;
  } stim_t;

  logic clk;
  logic rst_n;
  int   phase;
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_w(input int k);
    return (k == 3) ? 1 : 10;
  endfunction

  function automatic int cfg_g(input int k);
    case (k)
      0:       return 1;
      2:       return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_m(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = cfg_w(k);
    localparam int G = cfg_g(k);
    localparam int M = cfg_m(k);

    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         port_b;
    logic         busy;
`ifdef DEFINE_A
    logic         port_a;
    logic         port_c;
`endif
    exp_t         exp_q[$];
    stim_t        stim_q[$];
    int           cur_bit;
    logic         quiet;

    frame_serializer #(
      .WIDTH    (W),
      .IDLE_GAP (G),
      .MSB_FIRST(M)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid),
      .o_ready (ready),
      .i_data  (data),
      .o_port_b(port_b),
`ifdef DEFINE_A
      .o_port_a(port_a),
      .o_port_c(port_c),
`endif
      .o_busy  (busy)
    );

    // Stimulus programme for this instance
    initial begin
      if (k == 0) begin
        stim_q.push_back('{v: 1'b1, d: 64'h2A5});
        stim_q.push_back('{v: 1'b0, d: 64'h0});
        stim_q.push_back('{v: 1'b1, d: 64'h1C3});
      end else if (k == 1) begin
        stim_q.push_back('{v: 1'b1, d: 64'h3FF});
        stim_q.push_back('{v: 1'b1, d: 64'h000});
        stim_q.push_back('{v: 1'b1, d: 64'h155});
      end else if (k == 2) begin
        stim_q.push_back('{v: 1'b1, d: 64'h200});
      end else begin
        stim_q.push_back('{v: 1'b1, d: 64'h1});
        stim_q.push_back('{v: 1'b1, d: 64'h0});
        stim_q.push_back('{v: 1'b0, d: 64'h0});
        stim_q.push_back('{v: 1'b1, d: 64'h1});
      end
      for (int i = 0; i < 4; i++) begin
        stim_q.push_back('{v: 1'b1, d: {$urandom, $urandom}});
        if (i % 2 == 1) stim_q.push_back('{v: 1'b0, d: 64'h0});
      end
      if (k == 0) begin
        wait (phase == 2);
        stim_q.push_back('{v: 1'b1, d: 64'h3A7});
        stim_q.push_back('{v: 1'b1, d: 64'h2A5});
      end
    end

    // Per-cycle scoreboard check and handshake driver
    initial begin
      exp_t  e;
      exp_t  f;
      stim_t cur;
      logic  have;
      logic  bitv;
      have    = 1'b0;
      valid   = 1'b0;
      data    = '0;
      cur_bit = -1;
      quiet   = 1'b0;
      cur     = '{v: 1'b0, d: 64'h0};
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          e = '{busy: 1'b0, b: 1'b0, a: 1'b0, c: 1'b0, ready: 1'b1, idx: -1};
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
        end else begin
          e = '{busy: 1'b0, b: 1'b0, a: 1'b0, c: 1'b0, ready: 1'b1, idx: -1};
        end
        cur_bit = e.idx;
        check($sformatf("u%0d.busy", k), busy, e.busy);
        check($sformatf("u%0d.port_b", k), port_b, e.b);
        check($sformatf("u%0d.ready", k), ready, e.ready);
`ifdef DEFINE_A
        check($sformatf("u%0d.port_a", k), port_a, e.a);
        check($sformatf("u%0d.port_c", k), port_c, e.c);
`endif
        if (!have && stim_q.size() != 0) begin
          cur  = stim_q.pop_front();
          have = 1'b1;
        end
        if (!rst_n || !have) begin
          valid = 1'b0;
          data  = W'($urandom);
        end else begin
          valid = cur.v;
          data  = cur.v ? cur.d[W-1:0] : W'($urandom);
          if (!cur.v) begin
            have = 1'b0;
          end else if (e.ready) begin
            for (int i = 0; i < W; i++) begin
              bitv = (M != 0) ? cur.d[W-1-i] : cur.d[i];
              f = '{busy: 1'b1, b: bitv, a: (i == 0), c: (i == W - 1),
                    ready: ((i == W - 1) && (G == 0)), idx: i};
              exp_q.push_back(f);
            end
            for (int i = 0; i < G; i++) begin
              f = '{busy: 1'b1, b: 1'b0, a: 1'b0, c: 1'b0, ready: 1'b0, idx: -1};
              exp_q.push_back(f);
            end
            have = 1'b0;
          end
        end
        quiet = !have && (stim_q.size() == 0) && (exp_q.size() == 0);
      end
    end
  end

  // Wait, within a cycle budget, for every instance to drain its work
  task automatic wait_quiet(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (g_dut[0].quiet && g_dut[1].quiet && g_dut[2].quiet && g_dut[3].quiet) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1'b1);
  endtask

  initial begin
    logic hit;
    n_vec = 0;
    n_bad = 0;
    phase = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    phase = 1;
    wait_quiet(3000);

    // Drop reset into the middle of a frame on the gap-1 instance
    phase = 2;
    hit   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (g_dut[0].cur_bit == 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_bit3", hit, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_quiet(500);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
